// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, addresses the instruction ROM and registers the
// returned word into the instruction register, with stall, redirect flush and halt handling.
module instruction_fetch #(
  parameter logic [7:0] START_ADDR = 8'd0,
  parameter logic [8:0] HALT_INSTR = 9'b011100010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  input  logic       jump_en,
  input  logic [7:0] jump_target,
  input  logic       branch_taken,
  input  logic [7:0] branch_offset,
  output logic [7:0] rom_address,
  input  logic [8:0] rom_instruction,
  output logic [8:0] instr,
  output logic       instr_valid,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic        [7:0] fetch_pc;
  logic              redirect;
  logic              is_halt;
  logic        [7:0] redirect_target;
  logic        [7:0] seq_pc;
  logic signed [7:0] offset_s;

  // Relative target wraps modulo 256; the offset is two's complement.
  function automatic logic [7:0] branch_target(input logic [7:0] base,
                                               input logic signed [7:0] offset);
    logic [7:0] sum;
    sum = base + $unsigned(offset);
    return sum;
  endfunction

  assign rom_address = fetch_pc;
  assign offset_s    = branch_offset;

  always_comb begin
    // A redirect only belongs to a live instruction in the IR.
    redirect        = instr_valid && (jump_en || branch_taken);
    redirect_target = jump_en ? jump_target : branch_target(pc, offset_s);
    is_halt         = (rom_instruction == HALT_INSTR);
    seq_pc          = fetch_pc + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= START_ADDR;
      instr       <= 9'd0;
      instr_valid <= 1'b0;
      pc          <= 8'd0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          instr_valid <= 1'b0;
          if (start) begin
            state    <= RUN;
            fetch_pc <= START_ADDR;
            halted   <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (redirect) begin
              // Word at the old fetch_pc is in the redirect shadow: drop it.
              fetch_pc    <= redirect_target;
              instr_valid <= 1'b0;
            end else begin
              instr       <= rom_instruction;
              pc          <= fetch_pc;
              instr_valid <= 1'b1;
              if (is_halt) begin
                state  <= HALTED;
                halted <= 1'b1;
              end else begin
                fetch_pc <= seq_pc;
              end
            end
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, with a program-level
// reference model feeding an expected-instruction queue that a monitor drains.
module tb_instruction_fetch;
  localparam logic [7:0] START_ADDR = 8'd0;
  localparam logic [8:0] HALT_INSTR = 9'b011100010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stall = 1'b0, jump_en = 1'b0, branch_taken = 1'b0;
  logic [7:0] jump_target = 8'd0, branch_offset = 8'd0;
  logic [7:0] rom_address, pc;
  logic [8:0] rom_instruction, instr;
  logic       instr_valid, halted;
  logic [8:0] rom [256];

  always #5 clk = ~clk;
  assign rom_instruction = rom[rom_address];

  instruction_fetch #(.START_ADDR(START_ADDR), .HALT_INSTR(HALT_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .jump_en(jump_en), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .rom_address(rom_address), .rom_instruction(rom_instruction),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Reference model: the program is either executing or not; when executing, each free
  // cycle either consumes a redirect (losing the shadow word) or delivers rom[next].
  typedef struct {logic [7:0] a; logic [8:0] w;} item_t;
  item_t      exp_q[$];
  bit         m_exec, m_halt, m_valid, edge_stall;
  logic [7:0] m_next, m_pc;
  logic [8:0] m_word;

  task automatic model_reset();
    m_exec = 0; m_halt = 0; m_valid = 0; m_next = START_ADDR; m_pc = 8'd0; m_word = 9'd0;
    edge_stall = 0;
    exp_q.delete();
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      edge_stall = stall;
      if (!m_exec) begin
        m_valid = 0;
        if (start) begin m_exec = 1; m_halt = 0; m_next = START_ADDR; end
      end else if (!stall) begin
        if (m_valid && jump_en) begin
          m_next = jump_target; m_valid = 0;
        end else if (m_valid && branch_taken) begin
          m_next = 8'((int'(m_pc) + int'($signed(branch_offset)) + 256) % 256); m_valid = 0;
        end else begin
          m_word = rom[m_next]; m_pc = m_next; m_valid = 1;
          exp_q.push_back('{a: m_next, w: m_word});
          if (m_word == HALT_INSTR) begin m_exec = 0; m_halt = 1; end
          else m_next = 8'((int'(m_next) + 1) % 256);
        end
      end
    end
  end

  // Monitor: a newly presented instruction pops the queue; a held one must not change.
  bit    prev_valid = 0;
  item_t last;
  always @(negedge clk) begin
    if (!rst_n) prev_valid = 0;
    else begin
      check("instr_valid", instr_valid, m_valid);
      check("halted", halted, m_halt);
      check("rom_address", rom_address, m_next);
      if (instr_valid) begin
        if (!prev_valid || !edge_stall) begin
          if (exp_q.size() == 0) fail("unexpected_instr");
          else begin
            last = exp_q.pop_front();
            check("pc", pc, last.a);
            check("instr", instr, last.w);
          end
        end else begin
          check("held_pc", pc, last.a);
          check("held_instr", instr, last.w);
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic set_in(input bit s, input bit stl, input bit je, input logic [7:0] jt,
                        input bit bt, input logic [7:0] bo);
    start = s; stall = stl; jump_en = je; jump_target = jt; branch_taken = bt; branch_offset = bo;
  endtask

  // Advance until the model shows a live IR at address a; returns on that negedge.
  task automatic run_to(input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    while (!(m_valid && m_pc == a) && n < 400) begin
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("timeout_run_to");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_rom_address"}, rom_address, START_ADDR);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      w = 9'($urandom);
      if (w == HALT_INSTR) w = w ^ 9'd1;
      rom[i] = w;
    end
    for (int i = 0; i < 4; i++) rom[i] = 9'd0;
    rom[19] = HALT_INSTR;
    rom[41] = HALT_INSTR;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid", instr_valid, 0);

    // Start latency and sequential fetch from START_ADDR.
    set_in(1, 0, 0, 0, 0, 0);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    check("start_edge1_valid", instr_valid, 0);
    @(negedge clk);
    check("start_edge2_valid", instr_valid, 1);
    check("start_pc", pc, START_ADDR);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("seq_pc", pc, k);
    end

    // Stall for three cycles at pc 5.
    run_to(8'd5);
    set_in(0, 1, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      check("stall_pc", pc, 5);
      check("stall_rom_address", rom_address, 6);
    end
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("after_stall_pc", pc, 6);

    // Jump, branch back, and both together.
    run_to(8'd14);
    set_in(0, 0, 1, 8'd8, 0, 0);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    check("jump_bubble", instr_valid, 0);
    @(negedge clk);
    check("jump_pc", pc, 8);
    run_to(8'd14);
    set_in(0, 0, 0, 0, 1, 8'hFE);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    check("branch_bubble", instr_valid, 0);
    @(negedge clk);
    check("branch_pc", pc, 12);
    run_to(8'd14);
    set_in(0, 0, 1, 8'd8, 1, 8'hFE);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("jump_wins_pc", pc, 8);

    // Halt at 19, then restart with a simultaneous (ignored) jump.
    run_to(8'd19);
    check("halt_word_valid", instr_valid, 1);
    repeat (2) begin
      @(negedge clk);
      check("halted_flag", halted, 1);
      check("halted_valid", instr_valid, 0);
      check("halted_rom_address", rom_address, 19);
    end
    set_in(1, 0, 1, 8'd77, 0, 0);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    check("restart_halted_clear", halted, 0);
    @(negedge clk);
    check("restart_pc", pc, START_ADDR);

    // Halt word in a jump shadow, wrap at 255, asynchronous reset mid-run.
    run_to(8'd2);
    set_in(0, 0, 1, 8'd40, 0, 0);
    run_to(8'd40);
    set_in(0, 0, 1, 8'd250, 0, 0);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("shadow_halt_pc", pc, 250);
    check("shadow_not_halted", halted, 0);
    run_to(8'd255);
    @(negedge clk);
    check("wrap_pc", pc, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      w = 9'($urandom);
      if ($urandom_range(0, 19) == 0) w = HALT_INSTR;
      rom[i] = w;
    end
    @(negedge clk); rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, 8'($urandom),
             $urandom_range(0, 9) == 0, 8'($urandom));
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
